// File: rtl/bfp_norm_if.sv
// Sample-stream bundle for the block-floating-point normalizer.
// The producer/consumer side uses the master modport. The normalizer uses the slave modport.
interface bfp_norm_if #(
    parameter int WIDTH = 16,
    parameter int EXP_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [EXP_W-1:0] out_exp;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_last
    );
endinterface

// File: rtl/bfp_norm_ctrl.sv
// Block-floating-point normalizer.
// The block collects BLOCK_LEN signed samples and tracks the smallest redundant-sign-bit count.
// It then replays the block, shifting each sample left by that common exponent.
// Optional macro BFP_NORM_EXP_CAP_EN limits the registered exponent to MAX_EXP.
//
// state | meaning
// FILL  | accepting samples, tracking running minimum rsb
// DRAIN | replaying buf[rd_idx] <<< exp, exponent frozen
module bfp_norm_ctrl #(
    parameter int WIDTH     = 16,
    parameter int BLOCK_LEN = 8,
    parameter int EXP_W     = $clog2(WIDTH),
    parameter int MAX_EXP   = WIDTH - 1
) (
    input  logic      clk,
    input  logic      rst_n,
    bfp_norm_if.slave bus
);
    localparam int IDX_W = $clog2(BLOCK_LEN);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [EXP_W-1:0] exp_q;
    logic [WIDTH-1:0] sample_buf [BLOCK_LEN];

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [EXP_W-1:0] out_exp_q;
    logic             out_last_q;

    logic             in_hs;
    logic             last_wr;
    logic [EXP_W-1:0] rsb_in;
    logic [EXP_W-1:0] exp_run;
    logic [EXP_W-1:0] exp_fin;
    logic [IDX_W-1:0] rd_next;

    // Count the bits below the MSB that match it, stopping at the first one that differs.
    function automatic logic [EXP_W-1:0] rsb_f(input logic [WIDTH-1:0] x);
        logic             run;
        logic [EXP_W-1:0] n;
        run = 1'b1;
        n   = '0;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[WIDTH-1])) n = n + 1'b1;
            else                              run = 1'b0;
        end
        return n;
    endfunction

    assign in_hs   = (state == FILL) && bus.in_valid;
    assign last_wr = (wr_idx == IDX_W'(BLOCK_LEN - 1));
    assign rsb_in  = rsb_f(bus.in_data);
    assign rd_next = rd_idx + 1'b1;

    // The first sample of a block restarts the minimum, so the previous block's exponent cannot leak in.
    assign exp_run = (wr_idx == '0) ? rsb_in : ((rsb_in < exp_q) ? rsb_in : exp_q);

`ifdef BFP_NORM_EXP_CAP_EN
    assign exp_fin = (exp_run > EXP_W'(MAX_EXP)) ? EXP_W'(MAX_EXP) : exp_run;
`else
    assign exp_fin = exp_run;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_last  = out_last_q;

    // Sample storage: no reset, because the contents are rewritten before every replay.
    always_ff @(posedge clk) begin
        if (in_hs) sample_buf[wr_idx] <= bus.in_data;
    end

    // Sequencer. Outputs are loaded one beat ahead, so each output is a plain flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exp_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_hs) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (last_wr) begin
                            exp_q       <= exp_fin;
                            rd_idx      <= '0;
                            state       <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= sample_buf[0] << exp_fin;
                            out_exp_q   <= exp_fin;
                            out_last_q  <= 1'b0;
                        end else begin
                            exp_q <= exp_run;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            rd_idx      <= '0;
                            state       <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_exp_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            rd_idx     <= rd_next;
                            out_data_q <= sample_buf[rd_next] << exp_q;
                            out_last_q <= (rd_next == IDX_W'(BLOCK_LEN - 1));
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bfp_norm_ctrl.sv
// Directed bench for bfp_norm_ctrl (WIDTH=16, BLOCK_LEN=4).
// Inputs change on the falling edge, and outputs are checked there too.
module tb_bfp_norm_ctrl;
    localparam int W    = 16;
    localparam int BL   = 4;
    localparam int EW   = 4;
    localparam int MAXE = 4;

    typedef struct packed {
        logic [3:0][15:0] din;
        logic [3:0]       exp;
        logic [3:0][15:0] dout;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs [4];

    always #5 clk = ~clk;

    bfp_norm_if #(.WIDTH(W), .EXP_W(EW)) bus ();

    bfp_norm_ctrl #(.WIDTH(W), .BLOCK_LEN(BL), .MAX_EXP(MAXE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [3:0] eff_exp(input logic [3:0] e);
`ifdef BFP_NORM_EXP_CAP_EN
        return (e > 4'(MAXE)) ? 4'(MAXE) : e;
`else
        return e;
`endif
    endfunction

    function automatic logic [15:0] eff_data(input logic [15:0] din, input logic [15:0] dout,
                                             input logic [3:0] e);
`ifdef BFP_NORM_EXP_CAP_EN
        return din << eff_exp(e);
`else
        return dout;
`endif
    endfunction

    task automatic wait_in_ready();
        int c;
        c = 0;
        while (!bus.in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
    endtask

    task automatic wait_out_valid();
        int c;
        c = 0;
        while (!bus.out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!bus.out_valid) check("out_valid_timeout", bus.out_valid, 1);
    endtask

    task automatic send_block(input logic [3:0][15:0] din, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                bus.in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            wait_in_ready();
            if (i == BL - 1) check("pre_last_out_valid", bus.out_valid, 0);
            bus.in_valid = 1'b1;
            bus.in_data  = din[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic recv_block(input vec_t v, input int bp_beat);
        logic [15:0] ed;
        for (int j = 0; j < BL; j++) begin
            wait_out_valid();
            ed = eff_data(v.din[j], v.dout[j], v.exp);
            if (j == bp_beat) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, ed);
                    check("hold_exp", bus.out_exp, eff_exp(v.exp));
                    check("hold_in_ready", bus.in_ready, 0);
                    @(negedge clk);
                end
            end
            bus.out_ready = 1'b1;
            check("out_data", bus.out_data, ed);
            check("out_exp", bus.out_exp, eff_exp(v.exp));
            check("out_last", bus.out_last, (j == BL - 1) ? 1 : 0);
            check("drain_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_data", bus.out_data, 0);
        check("post_out_last", bus.out_last, 0);
    endtask

    initial begin
        vecs[0] = '{din: {16'h0000, 16'h0001, 16'hFFF0, 16'h0010}, exp: 4'd10,
                    dout: {16'h0000, 16'h0400, 16'hC000, 16'h4000}};
        vecs[1] = '{din: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp: 4'd15,
                    dout: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[2] = '{din: {16'h0001, 16'hFFFF, 16'h1234, 16'h8000}, exp: 4'd0,
                    dout: {16'h0001, 16'hFFFF, 16'h1234, 16'h8000}};
        vecs[3] = '{din: {16'h0000, 16'hFE00, 16'h0200, 16'h0100}, exp: 4'd5,
                    dout: {16'h0000, 16'hC000, 16'h4000, 16'h2000}};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_exp", bus.out_exp, 0);
        check("rst_out_last", bus.out_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back blocks, with random input gaps on the last one.
        for (int v = 0; v < 4; v++) begin
            send_block(vecs[v].din, BL, v == 3);
            check("latency_out_valid", bus.out_valid, 1);
            recv_block(vecs[v], -1);
        end

        // Stall on the second beat.
        send_block(vecs[0].din, BL, 1'b0);
        recv_block(vecs[0], 1);

        // Reset after two drain beats.
        send_block(vecs[0].din, BL, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_out_exp", bus.out_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(vecs[3].din, BL, 1'b0);
        recv_block(vecs[3], -1);

        // Reset during a partial fill, then send a fresh block.
        send_block(vecs[2].din, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("fill_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(vecs[0].din, BL, 1'b0);
        recv_block(vecs[0], -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
